// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// Optional feature macro: HAZARD_FORWARDING_EN (EX/MEM and MEM/WB bypass).
package hazard_pkg;

    // One in-flight pipeline slot as seen by the hazard logic
    typedef struct packed {
        logic [2:0] rd;
        logic       wr;
        logic       load;
    } trk_entry_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam trk_entry_t TRK_BUBBLE    = '{rd: 3'd0, wr: 1'b0, load: 1'b0};
    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    // Youngest producer wins: the ex slot shadows the mem slot
    function automatic logic [1:0] fwd_select(input logic hit_ex, input logic hit_mem);
        if (hit_ex)
            return FWD_EXMEM;
        else if (hit_mem)
            return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_compare.sv
// Compares one decode source register against both tracker slots.
module hazard_compare
    import hazard_pkg::*;
(
    input  logic [2:0] src,
    input  logic       src_valid,
    input  trk_entry_t ex_entry,
    input  trk_entry_t mem_entry,
    output logic       hit_ex,
    output logic       hit_mem,
    output logic       hit_ex_load
);

    // The load flag of the mem slot never matters: its data is ready by then
    logic unused_mem_load;
    assign unused_mem_load = mem_entry.load;

    // Register-number match against each in-flight producer
    always_comb begin
        hit_ex      = src_valid & ex_entry.wr  & (ex_entry.rd  == src);
        hit_mem     = src_valid & mem_entry.wr & (mem_entry.rd == src);
        hit_ex_load = hit_ex & ex_entry.load;
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stall generation, operand-forward selects and a
// saturating stall counter. Build option: HAZARD_FORWARDING_EN enables
// bypassing so only load-use dependencies stall.
module hazard_unit
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_rs_valid,
    input  logic        id_rt_valid,
    input  logic [2:0]  id_rd,
    input  logic        id_rd_valid,
    input  logic        id_reg_write,
    input  logic        id_is_load,
    input  logic        id_valid,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  fwd_rs_sel,
    output logic [1:0]  fwd_rt_sel,
    output logic [15:0] stall_cycles
);

    trk_entry_t  ex_q;
    trk_entry_t  mem_q;
    trk_entry_t  id_entry;
    logic        rs_hit_ex, rs_hit_mem, rs_hit_ex_load;
    logic        rt_hit_ex, rt_hit_mem, rt_hit_ex_load;
    logic        hazard;
    logic        bubble;
    logic [1:0]  rs_sel_d;
    logic [1:0]  rt_sel_d;
    logic [1:0]  fwd_rs_q;
    logic [1:0]  fwd_rt_q;
    logic [15:0] cnt_q;

    hazard_compare u_cmp_rs (
        .src         (id_rs),
        .src_valid   (id_rs_valid),
        .ex_entry    (ex_q),
        .mem_entry   (mem_q),
        .hit_ex      (rs_hit_ex),
        .hit_mem     (rs_hit_mem),
        .hit_ex_load (rs_hit_ex_load)
    );

    hazard_compare u_cmp_rt (
        .src         (id_rt),
        .src_valid   (id_rt_valid),
        .ex_entry    (ex_q),
        .mem_entry   (mem_q),
        .hit_ex      (rt_hit_ex),
        .hit_mem     (rt_hit_mem),
        .hit_ex_load (rt_hit_ex_load)
    );

    // Hazard detection and next-cycle forward selects for the decode instruction
    always_comb begin
        hazard   = 1'b0;
        rs_sel_d = FWD_RF;
        rt_sel_d = FWD_RF;
`ifdef HAZARD_FORWARDING_EN
        hazard   = rs_hit_ex_load | rt_hit_ex_load;
        rs_sel_d = fwd_select(rs_hit_ex, rs_hit_mem);
        rt_sel_d = fwd_select(rt_hit_ex, rt_hit_mem);
`else
        hazard   = rs_hit_ex | rs_hit_mem | rt_hit_ex | rt_hit_mem;
`endif
    end

`ifndef HAZARD_FORWARDING_EN
    // Load-use distinction is irrelevant when every dependency stalls
    logic unused_load_hits;
    assign unused_load_hits = rs_hit_ex_load | rt_hit_ex_load;
`endif

    // Flush and empty decode slots suppress stalling; any of them injects a bubble
    always_comb begin
        stall    = hazard & id_valid & ~flush;
        bubble   = stall | flush | ~id_valid;
        id_entry = '{rd:   id_rd,
                     wr:   id_valid & id_rd_valid & id_reg_write,
                     load: id_is_load};
    end

    // Tracker shift, registered forward selects and saturating stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q     <= TRK_BUBBLE;
            mem_q    <= TRK_BUBBLE;
            fwd_rs_q <= FWD_RF;
            fwd_rt_q <= FWD_RF;
            cnt_q    <= '0;
        end else begin
            mem_q    <= ex_q;
            ex_q     <= bubble ? TRK_BUBBLE : id_entry;
            fwd_rs_q <= bubble ? FWD_RF : rs_sel_d;
            fwd_rt_q <= bubble ? FWD_RF : rt_sel_d;
            if (stall && (cnt_q != STALL_CNT_MAX))
                cnt_q <= cnt_q + 16'd1;
        end
    end

    assign fwd_rs_sel   = fwd_rs_q;
    assign fwd_rt_sel   = fwd_rt_q;
    assign stall_cycles = cnt_q;

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- id_rs, id_rt  in  3 each  decode-stage source register numbers
- id_rs_valid, id_rt_valid  in  1 each  source is actually read
- id_rd  in  3  decode-stage destination register number
- id_rd_valid  in  1  destination field is meaningful
- id_reg_write  in  1  instruction writes the register file (0 for ST, branches, J, JR)
- id_is_load  in  1  instruction is LD
- id_valid  in  1  decode holds a real instruction (0 = bubble)
- flush  in  1  taken branch/jump; kill the decode instruction
- stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
- fwd_rs_sel, fwd_rt_sel  out  2 each  EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
- stall_cycles  out  16  saturating count of stall cycles

Function
REQ-003 The block SHALL hold a 2-entry in-flight tracker, ex then mem; each entry holds {rd[2:0], wr, load}.
REQ-004 A decode instruction SHALL become a producer only when id_valid & id_rd_valid & id_reg_write; otherwise it enters the tracker with wr=0.
REQ-005 Each clock the tracker SHALL shift: mem <= ex, and ex <= decode entry, or a bubble (wr=0) when stall | flush | !id_valid.
REQ-006 A match SHALL mean: source valid, entry wr=1, and entry rd equals the source register; R0 is not special.
REQ-007 The register file bypasses write-before-read, so the write-back stage SHALL never cause a hazard.
REQ-008 stall SHALL be combinational from the current inputs and tracker state, and SHALL be 0 whenever flush=1 or id_valid=0.
REQ-009 Simultaneous flush and hazard: flush SHALL win; stall=0 and the tracker takes a bubble.
REQ-010 fwd_rs_sel and fwd_rt_sel SHALL be registered: computed in ID, presented during the cycle that instruction occupies EX.
- Both are 00 when a bubble enters EX.
REQ-011 stall_cycles SHALL increment on every cycle with stall=1 and saturate at 16'hFFFF.

Reset
REQ-012 On rst=1 at a clock edge, the block SHALL:
- clear both tracker entries to wr=0, load=0, rd=0
- set fwd_rs_sel and fwd_rt_sel to 00
- set stall_cycles to 0
REQ-013 A reset mid-stall SHALL take effect at that edge; stall SHALL be 0 in the following cycle unless a new hazard arises from the current inputs.

Configuration
REQ-014 With macro HAZARD_FORWARDING_EN defined:
- stall=1 only when a source matches ex with ex.load=1, giving a 1-cycle load-use stall
- select 01 when the source matches ex (non-load)
- else select 10 when it matches mem
- ex has priority over mem
REQ-015 Without HAZARD_FORWARDING_EN:
- stall=1 when any valid source matches ex or mem, giving a stall of up to 2 cycles
- fwd_rs_sel and fwd_rt_sel are held at 00

Structure
REQ-016 A shared package hazard_pkg SHALL hold:
- the tracker entry struct type
- the FWD_RF=00, FWD_EXMEM=01 and FWD_MEMWB=10 constants
REQ-017 Source-versus-entries matching SHALL be one combinational sub-module, hazard_compare, instantiated once for Rs and once for Rt.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- ADD r3 then ADD r4,r3,r1 back-to-back -> with forwarding: stall 0, fwd_rs_sel=01 in the consumer's EX cycle; without: stall high for 2 cycles, then fwd 00.
- LD r2 then SUB r5,r2,r2 -> with forwarding: stall exactly 1 cycle, then fwd_rs_sel=fwd_rt_sel=10; stall_cycles=1.
- ST r2,[r1] then ADD r4,r2,r1 -> no stall (ST tracked with wr=0), fwd 00.
- Hazard present with flush=1 in the same cycle -> stall 0; ex tracker bubble; next instruction sees no match.
- rst asserted during the second cycle of a non-forwarding stall -> stall 0 next cycle; stall_cycles=0; fwd 00.
- Force 65,540 stall cycles -> stall_cycles holds 16'hFFFF.
